// File: rtl/pong_pkg.sv
// Shared encodings for the pong paddle button/acknowledge protocol and the AI player FSM.
package pong_pkg;

  localparam logic [1:0] ACT_NONE  = 2'b00;
  localparam logic [1:0] ACT_RIGHT = 2'b01;
  localparam logic [1:0] ACT_LEFT  = 2'b11;

  localparam logic [1:0] BTN_NONE  = 2'b00;
  localparam logic [1:0] BTN_RIGHT = 2'b01;
  localparam logic [1:0] BTN_LEFT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_RELEASE,
    ST_HOLDOFF
  } ai_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pong_lfsr.sv
// 8-bit maximal Galois LFSR (taps 8,6,5,4) with enable and synchronous reset to SEED.
module pong_lfsr #(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [OUT_W-1:0] value
);

  logic [7:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[7:1]} ^ (state[0] ? 8'hB8 : 8'h00);
    end
  end

  assign value = state[OUT_W-1:0];

endmodule

// File: rtl/ai_player.sv
// Computer opponent driving the paddle buttons: one press per step, then release and hold-off.
// AI_PLAYER_JITTER_EN adds 0..3 pseudo-random cycles to each hold-off.
module ai_player
  import pong_pkg::*;
#(
  parameter int BIT_WIDTH     = 3,
  parameter int SIZE          = 2,
  parameter int MOVE_DELAY    = 4,
  parameter int PRESS_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [BIT_WIDTH-1:0] ball_x,
  input  logic                 ball_valid,
  input  logic [BIT_WIDTH-1:0] paddle_left,
  input  logic [1:0]           action,
  output logic                 left,
  output logic                 right,
  output logic                 busy
);

`ifdef AI_PLAYER_JITTER_EN
  localparam int JIT_MAX = 3;
`else
  localparam int JIT_MAX = 0;
`endif
  localparam int CNT_MAX = max2(MOVE_DELAY + JIT_MAX, PRESS_TIMEOUT);
  localparam int CW      = $clog2(CNT_MAX + 1);

  ai_state_t         state;
  logic              dir_left;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_inc;
  logic [CW-1:0]     hold_len;
  logic [BIT_WIDTH:0] paddle_right;
  logic              go_left;
  logic              go_right;
  logic              acked;

  // Span end is one bit wider so a paddle touching the right wall never wraps to 0.
  assign paddle_right = {1'b0, paddle_left} + (BIT_WIDTH+1)'(SIZE - 1);
  assign go_left      = ball_valid && (ball_x < paddle_left);
  assign go_right     = ball_valid && ({1'b0, ball_x} > paddle_right);
  assign acked        = (action == (dir_left ? ACT_LEFT : ACT_RIGHT));
  assign cnt_inc      = (cnt == CW'(CNT_MAX)) ? cnt : cnt + 1'b1;

`ifdef AI_PLAYER_JITTER_EN
  logic [1:0] jitter;

  pong_lfsr #(
    .SEED  (8'hA5),
    .OUT_W (2)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .value (jitter)
  );
`else
  assign hold_len = CW'(MOVE_DELAY);
`endif

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state    <= ST_IDLE;
      dir_left <= 1'b0;
      cnt      <= '0;
      left     <= 1'b0;
      right    <= 1'b0;
      busy     <= 1'b0;
`ifdef AI_PLAYER_JITTER_EN
      hold_len <= CW'(MOVE_DELAY);
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (go_left || go_right) begin
            state    <= ST_PRESS;
            dir_left <= go_left;
            left     <= go_left;
            right    <= !go_left;
            busy     <= 1'b1;
          end
        end
        ST_PRESS: begin
          // Mismatching acknowledgements simply fall through to the timeout.
          if (acked || (cnt_inc >= CW'(PRESS_TIMEOUT))) begin
            state <= ST_RELEASE;
            left  <= 1'b0;
            right <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_RELEASE: begin
          state <= ST_HOLDOFF;
          cnt   <= '0;
`ifdef AI_PLAYER_JITTER_EN
          hold_len <= CW'(MOVE_DELAY) + CW'(jitter);
`endif
        end
        default: begin
          if (cnt_inc >= hold_len) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ai_player.sv
// Self-checking bench for ai_player: directed scenarios plus randomized steps against a rule-level model.
module tb_ai_player;
  import pong_pkg::*;

  localparam int BW            = 3;
  localparam int SIZE          = 2;
  localparam int MOVE_DELAY    = 4;
  localparam int PRESS_TIMEOUT = 8;
  // Zero cycles between presses: release + hold-off + idle decision.
  localparam int GAP = 1 + MOVE_DELAY + 1;
`ifdef AI_PLAYER_JITTER_EN
  localparam int JIT = 3;
`else
  localparam int JIT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [BW-1:0] ball_x;
  logic          ball_valid;
  logic [BW-1:0] paddle_left;
  logic [1:0]    action;
  logic          left;
  logic          right;
  logic          busy;

  int checks = 0;
  int errors = 0;

  ai_player #(
    .BIT_WIDTH     (BW),
    .SIZE          (SIZE),
    .MOVE_DELAY    (MOVE_DELAY),
    .PRESS_TIMEOUT (PRESS_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .ball_x      (ball_x),
    .ball_valid  (ball_valid),
    .paddle_left (paddle_left),
    .action      (action),
    .left        (left),
    .right       (right),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [1:0] btn();
    return {left, right};
  endfunction

  // Which button the opponent should press for a given ball/paddle.
  function automatic logic [1:0] model_dir(input int bx, input int pl, input logic v);
    if (!v) return BTN_NONE;
    if (bx < pl) return BTN_LEFT;
    if (bx > pl + SIZE - 1) return BTN_RIGHT;
    return BTN_NONE;
  endfunction

  function automatic logic gap_ok(input int gap);
    return (gap >= GAP) && (gap <= GAP + JIT);
  endfunction

  task automatic restart(input int bx, input int pl, input logic v);
    en = 1'b0;
    tick();
    ball_x      = BW'(bx);
    paddle_left = BW'(pl);
    ball_valid  = v;
    action      = ACT_NONE;
    en          = 1'b1;
  endtask

  // Counts idle-button cycles until a press appears; zeros = -1 if none within bound.
  task automatic wait_press(input int bound, output int zeros, output logic [1:0] b,
                            output logic last_busy);
    zeros = 0;
    b = BTN_NONE;
    last_busy = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (btn() != BTN_NONE) begin
        b = btn();
        return;
      end
      zeros++;
      last_busy = busy;
    end
    zeros = -1;
  endtask

  // Acts as the paddle while a press is held; returns the press length in cycles.
  task automatic hold_press(input int ack_at, input logic [1:0] ack_val, input logic [1:0] wrong_val,
                            input logic bump, input int mv, output int len,
                            output logic busy_ok, output logic stable);
    logic [1:0]    b0;
    logic [BW-1:0] orig;
    b0 = btn();
    orig = ball_x;
    len = -1;
    busy_ok = 1'b1;
    stable = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      if (!busy) busy_ok = 1'b0;
      if (btn() != b0) stable = 1'b0;
      action = (k == ack_at) ? ack_val : wrong_val;
      if (mv >= 0 && k == 3) ball_x = BW'(mv);
      if (mv >= 0 && k == 6) ball_x = orig;
      tick();
      if (btn() == BTN_NONE) begin
        len = k;
        break;
      end
    end
    action = ACT_NONE;
    ball_x = orig;
    if (bump && len == ack_at) paddle_left = paddle_left + 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ball_valid = 1'b1; ball_x = 3'd1; paddle_left = 3'd4; action = ACT_NONE;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({left, right, busy} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got %b want 000", i, {left, right, busy});
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({left, right, busy} !== 3'b101) begin
      errors++;
      $display("FAIL first_press_after_reset got %b want 101", {left, right, busy});
    end
  endtask

  task automatic test_left_step();
    int z, len; logic [1:0] b; logic lb, bok, st;
    restart(1, 4, 1'b1);
    wait_press(5, z, b, lb);
    checks++;
    if (z !== 0 || b !== BTN_LEFT) begin
      errors++;
      $display("FAIL left_first_press zeros %0d btn %b want 0 %b", z, b, BTN_LEFT);
    end
    for (int s = 0; s < 3; s++) begin
      hold_press(1, ACT_LEFT, ACT_NONE, 1'b0, -1, len, bok, st);
      checks++;
      if (len !== 1 || !bok) begin
        errors++;
        $display("FAIL left_press_len step %0d got %0d busy_ok %b want 1", s, len, bok);
      end
      wait_press(20, z, b, lb);
      checks++;
      if (z < 0 || !gap_ok(z + 1) || b !== BTN_LEFT || lb !== 1'b0) begin
        errors++;
        $display("FAIL left_gap step %0d gap %0d btn %b idle_busy %b want %0d %b 0",
                 s, z + 1, b, lb, GAP, BTN_LEFT);
      end
    end
  endtask

  task automatic test_right_track();
    int z, len, presses; logic [1:0] b; logic lb, bok, st;
    restart(6, 2, 1'b1);
    presses = 0;
    for (int i = 0; i < 10; i++) begin
      wait_press(20, z, b, lb);
      if (z < 0) break;
      presses++;
      checks++;
      if (b !== BTN_RIGHT || (presses > 1 && !gap_ok(z + 1))) begin
        errors++;
        $display("FAIL right_step %0d btn %b gap %0d want %b %0d", presses, b, z + 1, BTN_RIGHT, GAP);
      end
      hold_press(1, ACT_RIGHT, ACT_NONE, 1'b1, -1, len, bok, st);
    end
    checks++;
    if (presses !== 3 || paddle_left !== 3'd5 || busy !== 1'b0) begin
      errors++;
      $display("FAIL right_track presses %0d paddle_left %0d busy %b want 3 5 0", presses, paddle_left, busy);
    end
  endtask

  task automatic test_timeout();
    int z, len; logic [1:0] b; logic lb, bok, st;
    restart(0, 3, 1'b1);
    wait_press(5, z, b, lb);
    hold_press(0, ACT_NONE, ACT_NONE, 1'b0, 7, len, bok, st);
    checks++;
    if (len !== PRESS_TIMEOUT || !st || !bok) begin
      errors++;
      $display("FAIL timeout_len got %0d stable %b busy_ok %b want %0d 1 1", len, st, bok, PRESS_TIMEOUT);
    end
    wait_press(20, z, b, lb);
    checks++;
    if (z < 0 || !gap_ok(z + 1) || b !== BTN_LEFT) begin
      errors++;
      $display("FAIL timeout_retry gap %0d btn %b want %0d %b", z + 1, b, GAP, BTN_LEFT);
    end
  endtask

  task automatic test_wrong_ack();
    int z, len; logic [1:0] b; logic lb, bok, st;
    restart(0, 3, 1'b1);
    wait_press(5, z, b, lb);
    hold_press(0, ACT_NONE, ACT_RIGHT, 1'b0, -1, len, bok, st);
    checks++;
    if (len !== PRESS_TIMEOUT) begin
      errors++;
      $display("FAIL wrong_ack_left got %0d want %0d", len, PRESS_TIMEOUT);
    end
    restart(7, 2, 1'b1);
    wait_press(5, z, b, lb);
    hold_press(4, ACT_RIGHT, ACT_LEFT, 1'b0, -1, len, bok, st);
    checks++;
    if (b !== BTN_RIGHT || len !== 4) begin
      errors++;
      $display("FAIL wrong_ack_right btn %b len %0d want %b 4", b, len, BTN_RIGHT);
    end
  endtask

  task automatic test_en_drop();
    int z; logic [1:0] b; logic lb;
    restart(0, 3, 1'b1);
    wait_press(5, z, b, lb);
    tick();
    en = 1'b0;
    tick();
    checks++;
    if ({left, right, busy} !== 3'b000) begin
      errors++;
      $display("FAIL en_drop got %b want 000", {left, right, busy});
    end
    ball_x = 3'd3;
    en = 1'b1;
    wait_press(30, z, b, lb);
    checks++;
    if (z !== -1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL inside_span zeros %0d busy %b want -1 0", z, busy);
    end
  endtask

  task automatic test_rst_mid_press();
    int z; logic [1:0] b; logic lb;
    restart(7, 0, 1'b1);
    wait_press(5, z, b, lb);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({left, right, busy} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid_press got %b want 000", {left, right, busy});
    end
  endtask

  task automatic test_random();
    int pl, bx, ack_at, z, len, exp_len; logic v; logic [1:0] exp, b, ackv, wv; logic lb, bok, st;
    for (int t = 0; t < 40; t++) begin
      pl = $urandom_range(0, 7);
      bx = $urandom_range(0, 7);
      v = ($urandom_range(0, 3) != 0);
      ack_at = $urandom_range(1, 10);
      exp = model_dir(bx, pl, v);
      restart(bx, pl, v);
      wait_press((exp == BTN_NONE) ? 12 : 3, z, b, lb);
      checks++;
      if (exp == BTN_NONE) begin
        if (z !== -1) begin
          errors++;
          $display("FAIL rand_nopress trial %0d ball %0d pl %0d v %b got btn %b", t, bx, pl, v, b);
        end
        continue;
      end
      if (z !== 0 || b !== exp) begin
        errors++;
        $display("FAIL rand_dir trial %0d ball %0d pl %0d got %b want %b", t, bx, pl, b, exp);
        continue;
      end
      ackv = (exp == BTN_LEFT) ? ACT_LEFT : ACT_RIGHT;
      wv = ACT_NONE;
      if ($urandom_range(0, 1) != 0) wv = ($urandom_range(0, 1) != 0) ? 2'b10 : (ackv ^ 2'b10);
      hold_press(ack_at, ackv, wv, 1'b0, -1, len, bok, st);
      exp_len = (ack_at <= PRESS_TIMEOUT) ? ack_at : PRESS_TIMEOUT;
      checks++;
      if (len !== exp_len || !st || !bok) begin
        errors++;
        $display("FAIL rand_len trial %0d got %0d want %0d stable %b busy_ok %b", t, len, exp_len, st, bok);
      end
      wait_press(20, z, b, lb);
      checks++;
      if (z < 0 || !gap_ok(z + 1) || b !== exp) begin
        errors++;
        $display("FAIL rand_gap trial %0d gap %0d btn %b want %0d %b", t, z + 1, b, GAP, exp);
      end
    end
  endtask

  task automatic run_gaps(output int g[6]);
    int z, len; logic [1:0] b; logic lb, bok, st;
    rst = 1'b1; en = 1'b1; ball_valid = 1'b1; ball_x = 3'd0; paddle_left = 3'd3; action = ACT_NONE;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    wait_press(5, z, b, lb);
    for (int i = 0; i < 6; i++) begin
      hold_press(1, ACT_LEFT, ACT_NONE, 1'b0, -1, len, bok, st);
      wait_press(20, z, b, lb);
      g[i] = z + 1;
    end
  endtask

  task automatic test_holdoff_repeat();
    int g1[6];
    int g2[6];
    run_gaps(g1);
    run_gaps(g2);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (!gap_ok(g1[i]) || g1[i] !== g2[i]) begin
        errors++;
        $display("FAIL holdoff_gap %0d first %0d second %0d want %0d..%0d and equal",
                 i, g1[i], g2[i], GAP, GAP + JIT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_step();
    test_right_track();
    test_timeout();
    test_wrong_ack();
    test_en_drop();
    test_rst_mid_press();
    test_random();
    test_holdoff_repeat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
